// File: rtl/ram_bist_pkg.sv
// Shared types and constants for the ram_bist_ctrl March-style RAM self-test.
package ram_bist_pkg;

  // BIST sequencer states: background write, ascending read/invert, descending verify.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR0  = 3'd1,
    RD0  = 3'd2,
    WR1  = 3'd3,
    RD1  = 3'd4,
    CK1  = 3'd5,
    DONE = 3'd6
  } bist_state_e;

  // Default background pattern; the second pass writes its inverse.
  localparam logic [7:0] DEF_PATTERN = 8'h55;

  // A full run costs one cycle per address for the background write,
  // then two per address ascending and two per address descending.
  function automatic int unsigned total_cycles(input int unsigned depth);
    return 5 * depth;
  endfunction

  localparam int unsigned DEF_DEPTH  = 8;
  localparam int unsigned RUN_CYCLES = total_cycles(DEF_DEPTH);

endpackage

// File: rtl/ram_bist_addr_ctr.sv
// Address counter for the BIST sequencer: clear, load-max, increment and
// decrement (priority in that order) plus terminal-count flags.
module ram_bist_addr_ctr #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              ld_max,
  input  logic              inc,
  input  logic              dec,
  output logic [ADDR_W-1:0] addr,
  output logic              at_max,
  output logic              at_zero
);

  // Address register; holds its value when no control is asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
    end else if (clr) begin
      addr <= '0;
    end else if (ld_max) begin
      addr <= '1;
    end else if (inc) begin
      addr <= addr + ADDR_W'(1);
    end else if (dec) begin
      addr <= addr - ADDR_W'(1);
    end
  end

  assign at_max  = (addr == '1);
  assign at_zero = (addr == '0);

endmodule

// File: rtl/ram_bist_ctrl.sv
// March-style self-test initiator for the 8x8 synchronous RAM.
// Optional build macro RAM_BIST_ERRCNT_EN: adds err_cnt and runs to
// completion instead of aborting on the first mismatch.
// Memory port: the address is presented in a read state and the RAM's
// registered data is checked in the following state (WR1 or CK1).
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int                ADDR_W  = 3,
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] PATTERN = DATA_W'(DEF_PATTERN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
`ifdef RAM_BIST_ERRCNT_EN
  output logic [ADDR_W+1:0] err_cnt,
`endif
  output bist_state_e       dbg_state
);

  bist_state_e       state, next_state;
  logic              ctr_clr, ctr_ld_max, ctr_inc, ctr_dec;
  logic              at_max, at_zero;
  logic              clr_res;
  logic              chk;
  logic [DATA_W-1:0] exp_data;
  logic              mismatch;
  logic              abort;
  logic              enter_done;
  logic              err_seen;

  ram_bist_addr_ctr #(.ADDR_W(ADDR_W)) u_addr_ctr (
    .clk     (clk),
    .rst     (rst),
    .clr     (ctr_clr),
    .ld_max  (ctr_ld_max),
    .inc     (ctr_inc),
    .dec     (ctr_dec),
    .addr    (mem_addr),
    .at_max  (at_max),
    .at_zero (at_zero)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state, memory-port drive and counter control for the March sequence.
  always_comb begin
    next_state = state;
    ctr_clr    = 1'b0;
    ctr_ld_max = 1'b0;
    ctr_inc    = 1'b0;
    ctr_dec    = 1'b0;
    clr_res    = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    chk        = 1'b0;
    exp_data   = PATTERN;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          next_state = WR0;
          ctr_clr    = 1'b1;
          clr_res    = 1'b1;
        end
      end
      WR0: begin
        mem_we    = 1'b1;
        mem_wdata = PATTERN;
        if (at_max) begin
          ctr_clr    = 1'b1;
          next_state = RD0;
        end else begin
          ctr_inc = 1'b1;
        end
      end
      RD0: next_state = WR1;
      WR1: begin
        // Check the background and overwrite with the inverse in one cycle.
        mem_we    = 1'b1;
        mem_wdata = ~PATTERN;
        chk       = 1'b1;
        exp_data  = PATTERN;
        if (abort) begin
          next_state = DONE;
        end else if (at_max) begin
          ctr_ld_max = 1'b1;
          next_state = RD1;
        end else begin
          ctr_inc    = 1'b1;
          next_state = RD0;
        end
      end
      RD1: next_state = CK1;
      CK1: begin
        chk      = 1'b1;
        exp_data = ~PATTERN;
        if (abort || at_zero) begin
          next_state = DONE;
        end else begin
          ctr_dec    = 1'b1;
          next_state = RD1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign mismatch   = chk && (mem_rdata != exp_data);
`ifdef RAM_BIST_ERRCNT_EN
  assign abort      = 1'b0;
`else
  assign abort      = mismatch;
`endif
  assign enter_done = (state != DONE) && (next_state == DONE);

  // Result capture: first-failure address/data and the pass verdict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
      err_seen  <= 1'b0;
    end else if (clr_res) begin
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
      err_seen  <= 1'b0;
    end else begin
      if (mismatch && !err_seen) begin
        fail_addr <= mem_addr;
        fail_data <= mem_rdata;
        err_seen  <= 1'b1;
      end
      if (enter_done) begin
        pass <= !err_seen && !mismatch;
      end
    end
  end

`ifdef RAM_BIST_ERRCNT_EN
  // Saturating mismatch counter, cleared at the start of every run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (clr_res) begin
      err_cnt <= '0;
    end else if (mismatch && (err_cnt != '1)) begin
      err_cnt <= err_cnt + (ADDR_W+2)'(1);
    end
  end
`endif

  assign busy      = (state != IDLE) && (state != DONE);
  assign done      = (state == DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Self-checking bench for ram_bist_ctrl with a behavioural 8x8 RAM that can
// inject read faults. Expected bus traffic is queued when a run is launched
// and popped as the controller drives the memory port.
module tb_ram_bist_ctrl;
  import ram_bist_pkg::*;

  localparam int         ADDR_W = 3;
  localparam int         DATA_W = 8;
  localparam int         DEPTH  = 8;
  localparam logic [7:0] PAT    = 8'h55;
  localparam logic [7:0] INV    = 8'hAA;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy, done, pass;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_data;
`ifdef RAM_BIST_ERRCNT_EN
  logic [ADDR_W+1:0] err_cnt;
`endif
  bist_state_e       dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [11:0] exp_q[$];

  // RAM model state and fault selection: 0 none, 1 addr5 bit0 stuck-at-1, 2 addr2 reads 0.
  logic [7:0] ram [DEPTH];
  int         fault_mode = 0;

  ram_bist_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .fail_data (fail_data),
`ifdef RAM_BIST_ERRCNT_EN
    .err_cnt   (err_cnt),
`endif
    .dbg_state (dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Synchronous RAM: registered read-before-write, read-path fault injection.
  always @(posedge clk) begin : ram_model
    logic [7:0] rd;
    rd = ram[mem_addr];
    if (fault_mode == 1 && mem_addr == 3'd5) rd = rd | 8'h01;
    if (fault_mode == 2 && mem_addr == 3'd2) rd = 8'h00;
    mem_rdata <= rd;
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end

  // Global time limit.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Launch a run: start is high across exactly one sampling edge.
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Count edges from the sampling edge until done, bounded.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, pass, mem_we} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: busy/done/pass/we=%b expected 0000", {busy, done, pass, mem_we});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_port: addr=%0d wdata=%h expected 0/00", mem_addr, mem_wdata);
    end
    n_cmp++;
    if ({fail_addr, fail_data} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_fail_regs: fail_addr=%0d fail_data=%h expected 0/00", fail_addr, fail_data);
    end
    n_cmp++;
    if (dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d expected IDLE", dbg_state);
    end
    @(negedge clk) rst = 1'b0;
  endtask

  // Clean run with per-cycle check of the memory-port sequence.
  task automatic test_clean_sequence();
    logic [11:0] got, want;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({1'b1, 3'(i), PAT});
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back({1'b0, 3'(i), 8'h00});
      exp_q.push_back({1'b1, 3'(i), INV});
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      exp_q.push_back({1'b0, 3'(i), 8'h00});
      exp_q.push_back({1'b0, 3'(i), 8'h00});
    end
    pulse_start();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL clean_busy: busy=%b expected 1", busy);
    end
    for (int i = 0; i < int'(RUN_CYCLES); i++) begin
      if (i > 0) @(negedge clk);
      got  = {mem_we, mem_addr, mem_wdata};
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL seq_cycle%0d: we/addr/wdata=%b/%0d/%h expected %b/%0d/%h",
                 i, got[11], got[10:8], got[7:0], want[11], want[10:8], want[7:0]);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({done, pass, busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL clean_done_40: done/pass/busy=%b expected 110", {done, pass, busy});
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (ram[i] !== INV) begin
        n_fail++;
        $display("FAIL clean_ram%0d: ram=%h expected %h", i, ram[i], INV);
      end
    end
  endtask

  task automatic test_stuck_bit();
    int cyc;
    int exp_cyc;
`ifdef RAM_BIST_ERRCNT_EN
    exp_cyc = 40;
`else
    exp_cyc = 30;
`endif
    fault_mode = 1;
    pulse_start();
    wait_done(cyc);
    fault_mode = 0;
    n_cmp++;
    if (cyc !== exp_cyc) begin
      n_fail++;
      $display("FAIL stuck_cycles: done after %0d edges expected %0d", cyc, exp_cyc);
    end
    n_cmp++;
    if ({done, pass} !== 2'b10) begin
      n_fail++;
      $display("FAIL stuck_verdict: done/pass=%b expected 10", {done, pass});
    end
    n_cmp++;
    if (fail_addr !== 3'd5 || fail_data !== 8'hAB) begin
      n_fail++;
      $display("FAIL stuck_capture: addr=%0d data=%h expected 5/ab", fail_addr, fail_data);
    end
`ifdef RAM_BIST_ERRCNT_EN
    n_cmp++;
    if (err_cnt !== 5'd1) begin
      n_fail++;
      $display("FAIL stuck_errcnt: err_cnt=%0d expected 1", err_cnt);
    end
`endif
  endtask

  task automatic test_ascend_fault();
    int cyc;
    int exp_cyc;
`ifdef RAM_BIST_ERRCNT_EN
    exp_cyc = 40;
`else
    exp_cyc = 14;
`endif
    fault_mode = 2;
    pulse_start();
    wait_done(cyc);
    fault_mode = 0;
    n_cmp++;
    if (cyc !== exp_cyc) begin
      n_fail++;
      $display("FAIL ascend_cycles: done after %0d edges expected %0d", cyc, exp_cyc);
    end
    n_cmp++;
    if ({done, pass} !== 2'b10) begin
      n_fail++;
      $display("FAIL ascend_verdict: done/pass=%b expected 10", {done, pass});
    end
    n_cmp++;
    if (fail_addr !== 3'd2 || fail_data !== 8'h00) begin
      n_fail++;
      $display("FAIL ascend_capture: addr=%0d data=%h expected 2/00", fail_addr, fail_data);
    end
`ifdef RAM_BIST_ERRCNT_EN
    n_cmp++;
    if (err_cnt !== 5'd2) begin
      n_fail++;
      $display("FAIL ascend_errcnt: err_cnt=%0d expected 2", err_cnt);
    end
`endif
  endtask

  // Start pulses mid-run are dropped; also checks start clears the previous failure.
  task automatic test_start_while_busy();
    int cyc;
    pulse_start();
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      start = (cyc == 3 || cyc == 20);
    end
    start = 1'b0;
    n_cmp++;
    if (cyc !== 40) begin
      n_fail++;
      $display("FAIL busy_start_cycles: done after %0d edges expected 40", cyc);
    end
    n_cmp++;
    if ({pass, fail_addr, fail_data} !== 12'h800) begin
      n_fail++;
      $display("FAIL busy_start_result: pass=%b addr=%0d data=%h expected 1/0/00", pass, fail_addr, fail_data);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    fault_mode = 2;
    pulse_start();
    repeat (17) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, mem_we, pass} !== 4'b0000 || mem_addr !== 3'd0 || fail_addr !== 3'd0) begin
      n_fail++;
      $display("FAIL midrst_outputs: busy/done/we/pass=%b addr=%0d fail_addr=%0d expected 0000/0/0",
               {busy, done, mem_we, pass}, mem_addr, fail_addr);
    end
    #1 rst = 1'b0;
    fault_mode = 0;
    pulse_start();
    wait_done(cyc);
    n_cmp++;
    if (cyc !== 40 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_rerun: edges=%0d pass=%b expected 40/1", cyc, pass);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    wait_done(cyc);
    n_cmp++;
    if (cyc !== 40 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: edges=%0d pass=%b expected 40/1", cyc, pass);
    end
    @(negedge clk);
    n_cmp++;
    if ({done, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_restart: done/busy=%b expected 01", {done, busy});
    end
    wait_done(cyc);
    start = 1'b0;
    n_cmp++;
    if (cyc !== 40 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second: edges=%0d pass=%b expected 40/1", cyc, pass);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = 8'($urandom_range(0, 255));
    test_reset();
    test_clean_sequence();
    test_stuck_bit();
    test_ascend_fault();
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
